// File: rtl/string_hw_pkg.sv
// Shared constants and types for the string accelerator fetch path:
// window geometry, CSR map and the fetch FSM state type.
package string_hw_pkg;

    localparam int unsigned MAX_WORDS = 8;

    localparam logic [1:0] CSR_SRC    = 2'd0;
    localparam logic [1:0] CSR_CTRL   = 2'd1;
    localparam logic [1:0] CSR_STATUS = 2'd2;

    localparam int unsigned ST_BUSY_BIT  = 0;
    localparam int unsigned ST_DONE_BIT  = 1;
    localparam int unsigned ST_TRUNC_BIT = 2;
    localparam int unsigned ST_LEN_LSB   = 8;

    localparam int unsigned A_BASE = 1;
    localparam int unsigned B_BASE = MAX_WORDS + 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StWr,
        StPad
    } fetch_state_t;

endpackage

// File: rtl/nul_byte_finder.sv
// Locates the lowest-addressed zero byte of a little-endian 32-bit word.
module nul_byte_finder (
    input  logic [31:0] word_i,
    output logic        found_o,
    output logic [1:0]  idx_o
);

    always_comb begin
        found_o = 1'b1;
        idx_o   = 2'd0;
        if (word_i[7:0] == 8'h00) begin
            idx_o = 2'd0;
        end else if (word_i[15:8] == 8'h00) begin
            idx_o = 2'd1;
        end else if (word_i[23:16] == 8'h00) begin
            idx_o = 2'd2;
        end else if (word_i[31:24] == 8'h00) begin
            idx_o = 2'd3;
        end else begin
            found_o = 1'b0;
        end
    end

endmodule

// File: rtl/string_fetch_dma.sv
// Avalon-MM string fetch engine: copies a NUL-terminated string into the accelerator's
// A or B window. Define STRING_FETCH_PAD_EN to zero the unused tail of the window.
module string_fetch_dma
    import string_hw_pkg::*;
#(
    parameter int unsigned ACC_AW = $clog2(2 * MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic              csr_chipselect,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [31:0]       m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic [ACC_AW-1:0] acc_address,
    output logic              acc_write,
    output logic              acc_chipselect,
    output logic [31:0]       acc_writedata,
    output logic              irq
);

    localparam int unsigned WCW = $clog2(MAX_WORDS + 1);
    localparam logic [WCW-1:0] LAST_W = WCW'(MAX_WORDS - 1);

    fetch_state_t   state_q;
    logic [31:0]    src_q;
    logic [31:0]    data_q;
    logic           target_q;
    logic           done_q;
    logic           trunc_q;
    logic [7:0]     len_q;
    logic [WCW-1:0] w_q;
    logic [WCW-1:0] w_nxt;
    logic           nul_found;
    logic [1:0]     nul_idx;
    logic           csr_wr;
    logic           go;
    logic [31:0]    status_w;

    nul_byte_finder u_nul (
        .word_i  (data_q),
        .found_o (nul_found),
        .idx_o   (nul_idx)
    );

    function automatic logic [ACC_AW-1:0] win_addr(input logic tgt, input logic [WCW-1:0] w);
        return ACC_AW'((tgt ? B_BASE : A_BASE) + 32'(w));
    endfunction

    assign w_nxt  = w_q + WCW'(1);
    assign csr_wr = csr_write && csr_chipselect;
    // Sampling state_q also rejects a go that lands on the completion edge.
    assign go     = csr_wr && (csr_address == CSR_CTRL) && csr_writedata[0] && (state_q == StIdle);
    assign irq    = done_q;

    always_comb begin
        status_w                          = '0;
        status_w[ST_BUSY_BIT]             = (state_q != StIdle);
        status_w[ST_DONE_BIT]             = done_q;
        status_w[ST_TRUNC_BIT]            = trunc_q;
        status_w[ST_LEN_LSB +: 8]         = len_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            src_q          <= '0;
            data_q         <= '0;
            target_q       <= 1'b0;
            done_q         <= 1'b0;
            trunc_q        <= 1'b0;
            len_q          <= '0;
            w_q            <= '0;
            csr_readdata   <= '0;
            m_address      <= '0;
            m_read         <= 1'b0;
            acc_address    <= '0;
            acc_write      <= 1'b0;
            acc_chipselect <= 1'b0;
            acc_writedata  <= '0;
        end else begin
            if (csr_read && csr_chipselect) begin
                case (csr_address)
                    CSR_SRC:    csr_readdata <= src_q;
                    CSR_STATUS: csr_readdata <= status_w;
                    default:    csr_readdata <= '0;
                endcase
            end
            if (csr_wr && (csr_address == CSR_SRC)) begin
                src_q <= {csr_writedata[31:2], 2'b00};
            end
            if (csr_wr && (csr_address == CSR_STATUS)) begin
                done_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        target_q  <= csr_writedata[1];
                        done_q    <= 1'b0;
                        trunc_q   <= 1'b0;
                        len_q     <= '0;
                        w_q       <= '0;
                        m_read    <= 1'b1;
                        m_address <= src_q;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (!m_waitrequest) begin
                        m_read  <= 1'b0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (m_readdatavalid) begin
                        data_q         <= m_readdata;
                        acc_write      <= 1'b1;
                        acc_chipselect <= 1'b1;
                        acc_address    <= win_addr(target_q, w_q);
                        acc_writedata  <= m_readdata;
                        state_q        <= StWr;
                    end
                end
                StWr: begin
                    acc_write      <= 1'b0;
                    acc_chipselect <= 1'b0;
                    if (nul_found) begin
                        len_q <= 8'({w_q, nul_idx});
`ifdef STRING_FETCH_PAD_EN
                        if (w_q != LAST_W) begin
                            w_q            <= w_nxt;
                            acc_write      <= 1'b1;
                            acc_chipselect <= 1'b1;
                            acc_address    <= win_addr(target_q, w_nxt);
                            acc_writedata  <= '0;
                            state_q        <= StPad;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
`else
                        done_q  <= 1'b1;
                        state_q <= StIdle;
`endif
                    end else if (w_q == LAST_W) begin
                        trunc_q <= 1'b1;
                        len_q   <= 8'(4 * MAX_WORDS);
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        w_q       <= w_nxt;
                        m_read    <= 1'b1;
                        m_address <= src_q + 32'({w_nxt, 2'b00});
                        state_q   <= StReq;
                    end
                end
                StPad: begin
                    if (w_q == LAST_W) begin
                        acc_write      <= 1'b0;
                        acc_chipselect <= 1'b0;
                        done_q         <= 1'b1;
                        state_q        <= StIdle;
                    end else begin
                        w_q         <= w_nxt;
                        acc_address <= win_addr(target_q, w_nxt);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
